// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment word decoder.
// Segment patterns are active-low, ordered {seg6..seg0}.
package seg7_pkg;

    localparam logic [6:0] SEG7_PAT_0 = 7'b1000000;
    localparam logic [6:0] SEG7_PAT_1 = 7'b1111001;
    localparam logic [6:0] SEG7_PAT_2 = 7'b0100100;
    localparam logic [6:0] SEG7_PAT_3 = 7'b0110000;
    localparam logic [6:0] SEG7_PAT_4 = 7'b0011001;
    localparam logic [6:0] SEG7_PAT_5 = 7'b0010010;
    localparam logic [6:0] SEG7_PAT_6 = 7'b0000010;
    localparam logic [6:0] SEG7_PAT_7 = 7'b1111000;
    localparam logic [6:0] SEG7_PAT_8 = 7'b0000000;
    localparam logic [6:0] SEG7_PAT_9 = 7'b0011000;
    localparam logic [6:0] SEG7_PAT_A = 7'b0001000;
    localparam logic [6:0] SEG7_PAT_B = 7'b0000011;
    localparam logic [6:0] SEG7_PAT_C = 7'b1000110;
    localparam logic [6:0] SEG7_PAT_D = 7'b0100001;
    localparam logic [6:0] SEG7_PAT_E = 7'b0000110;
    localparam logic [6:0] SEG7_PAT_F = 7'b0001110;

    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low 7-segment pattern to hex nibble decoder.
// Anything outside the 16 hex glyphs (including blank) is flagged illegal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG7_PAT_0: nibble = 4'h0;
            SEG7_PAT_1: nibble = 4'h1;
            SEG7_PAT_2: nibble = 4'h2;
            SEG7_PAT_3: nibble = 4'h3;
            SEG7_PAT_4: nibble = 4'h4;
            SEG7_PAT_5: nibble = 4'h5;
            SEG7_PAT_6: nibble = 4'h6;
            SEG7_PAT_7: nibble = 4'h7;
            SEG7_PAT_8: nibble = 4'h8;
            SEG7_PAT_9: nibble = 4'h9;
            SEG7_PAT_A: nibble = 4'hA;
            SEG7_PAT_B: nibble = 4'hB;
            SEG7_PAT_C: nibble = 4'hC;
            SEG7_PAT_D: nibble = 4'hD;
            SEG7_PAT_E: nibble = 4'hE;
            SEG7_PAT_F: nibble = 4'hF;
            default:    legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_word_decoder.sv
// Collects NUM_DIGITS 7-segment digits into one hex word on a valid/ready port.
// SEG7_WORD_DECODER_ERRCNT_EN adds a saturating bad-digit counter output.
module seg7_word_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIG_W      = 2,
    parameter int ACTIVE_LOW = 1
)
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [6:0]              in_seg,
    input  logic [DIG_W-1:0]        in_digit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic                    out_err
`ifdef SEG7_WORD_DECODER_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int NW = 4 * NUM_DIGITS;
    localparam int XW = DIG_W + 1;

    state_t state_q, state_d;

    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [NW-1:0]         slot_q, slot_d;
    logic                  err_q, err_d;

    logic [6:0]  seg_al;
    logic        legal;
    logic [3:0]  nibble;
    logic        accept;
    logic        in_range;
    logic        bad;
    logic        complete;
    logic [XW-1:0] dig_ext;

    assign seg_al = (ACTIVE_LOW != 0) ? in_seg : ~in_seg;

    seg7_pattern_decode u_dec (
        .seg    (seg_al),
        .legal  (legal),
        .nibble (nibble)
    );

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // Extra bit keeps the range compare meaningful when NUM_DIGITS == 2**DIG_W.
    assign dig_ext  = {1'b0, in_digit};
    assign in_range = dig_ext < XW'(NUM_DIGITS);
    assign bad      = accept && (!in_range || !legal);

    always_comb begin
        slot_d = slot_q;
        mask_d = mask_q;
        err_d  = err_q;
        if (accept) begin
            if (bad) begin
                err_d = 1'b1;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (in_range && dig_ext == XW'(i)) begin
                    slot_d[4*i +: 4] = legal ? nibble : 4'h0;
                    mask_d[i]        = 1'b1;
                end
            end
        end
        complete = accept && (&mask_d);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (complete)  state_d = HOLD;
            HOLD:    if (out_ready) state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= COLLECT;
            mask_q    <= '0;
            slot_q    <= '0;
            err_q     <= 1'b0;
            out_value <= '0;
            out_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == HOLD) begin
                if (out_ready) begin
                    mask_q  <= '0;
                    err_q   <= 1'b0;
                    out_err <= 1'b0;
                end
            end else begin
                mask_q <= mask_d;
                slot_q <= slot_d;
                err_q  <= err_d;
                if (complete) begin
                    out_value <= slot_d;
                    out_err   <= err_d;
                end
            end
        end
    end

`ifdef SEG7_WORD_DECODER_ERRCNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= 8'd0;
        end else if (bad && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
